// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two valid/ready
// requesters. A round-robin arbiter accepts one operation at a time, drives
// the ALU from registers for one cycle and returns the tagged result.
// Optional feature macro: ALU_ARB_OPCHECK_EN (flag unsupported opcodes).
//
//  state | meaning
//  IDLE  | waiting; ready asserted only for the round-robin winner
//  ISSUE | alu_* driven from registers; result captured at the edge
//  RESP  | response held on rsp_* until rsp_ready
module alu_share_arbiter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic             busy,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last_grant;
    logic             r_id;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_err;
    logic             w_grant0;
    logic             w_grant1;
    logic             w_accept;
    logic             w_op_bad;
    logic [WIDTH-1:0] w_result;

    // Round-robin pick: a lone requester wins, a tie goes to the one not granted last
    always_comb begin
        w_grant0 = req0_valid && (!req1_valid || r_last_grant);
        w_grant1 = req1_valid && (!req0_valid || !r_last_grant);
    end

    // Next state and handshake outputs; ready is gated by rst_n so it reads 0 during reset
    always_comb begin
        w_state_nxt = r_state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                req0_ready = rst_n && w_grant0;
                req1_ready = rst_n && w_grant1;
                w_accept   = w_grant0 || w_grant1;
                if (w_accept) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef ALU_ARB_OPCHECK_EN
    // Unsupported opcodes return a forced-zero result with the error flag set
    always_comb begin
        case (r_op)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100: w_op_bad = 1'b0;
            default:                                     w_op_bad = 1'b1;
        endcase
        w_result = w_op_bad ? '0 : alu_result;
    end
`else
    // Every opcode is forwarded; the ALU output is taken as-is
    always_comb begin
        w_op_bad = 1'b0;
        w_result = alu_result;
    end
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Latch the winning request at the handshake; alu_* keep their values afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= 4'b0000;
        end else if (w_accept) begin
            r_last_grant <= w_grant1;
            r_id         <= w_grant1;
            r_a          <= w_grant1 ? req1_a  : req0_a;
            r_b          <= w_grant1 ? req1_b  : req0_b;
            r_op         <= w_grant1 ? req1_op : req0_op;
        end
    end

    // Capture the ALU result at the end of ISSUE; zero flag is derived locally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else if (r_state == S_ISSUE) begin
            r_result <= w_result;
            r_zero   <= !w_op_bad && (w_result == '0);
            r_err    <= w_op_bad;
        end
    end

    assign rsp_valid  = (r_state == S_RESP);
    assign busy       = (r_state != S_IDLE);
    assign rsp_id     = r_id;
    assign rsp_result = r_result;
    assign rsp_zero   = r_zero;
    assign rsp_err    = r_err;
    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_op     = r_op;

endmodule
